zap_utlb: RTL and testbench

ZAP_UTLB -- requirements
Module: zap_utlb

---
 rtl/zap_utlb.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_zap_utlb.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_utlb.sv
// Fully-associative micro-TLB with single outstanding lookup.
// Ports: i_clk/i_reset_n; request (i_req_valid/o_req_ready, i_va, i_rd, i_wr, i_user);
// live controls (i_mmu_en, i_sr, i_dac_reg); response (o_rsp_valid/i_rsp_ready,
// o_phy_addr, o_fsr, o_far, o_cacheable); walk request (o_walk, o_walk_va);
// walker fill (i_fill_*); i_inv flushes every entry.
module zap_utlb #(
   parameter int unsigned ENTRIES = 8
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_va,
   input  logic        i_rd,
   input  logic        i_wr,
   input  logic        i_user,
   input  logic        i_mmu_en,
   input  logic [1:0]  i_sr,
   input  logic [31:0] i_dac_reg,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_phy_addr,
   output logic [7:0]  o_fsr,
   output logic [31:0] o_far,
   output logic        o_cacheable,
   output logic        o_walk,
   output logic [31:0] o_walk_va,
   input  logic        i_fill_valid,
   input  logic        i_fill_fault,
   input  logic [7:0]  i_fill_fsr,
   input  logic [1:0]  i_fill_size,
   input  logic [21:0] i_fill_base,
   input  logic [1:0]  i_fill_ap,
   input  logic [3:0]  i_fill_dom,
   input  logic [1:0]  i_fill_cb,
   input  logic        i_inv
);

   localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam logic [1:0]  SZ_SECTION = 2'd0;
   localparam logic [1:0]  SZ_LARGE   = 2'd1;
   localparam logic [1:0]  SZ_SMALL   = 2'd2;

   typedef enum logic [1:0] {IDLE, CHECK, WALK, RESP} state_t;

   state_t             state_q, state_d;
   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [31:0]        va_q, va_d;
   logic               rd_q, rd_d, wr_q, wr_d, user_q, user_d;
   logic               req_ready_q, req_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [31:0]        phy_q, phy_d;
   logic [7:0]         fsr_q, fsr_d;
   logic [31:0]        far_q, far_d;
   logic               cache_q, cache_d;
   logic               walk_q, walk_d;
   logic [31:0]        walk_va_q, walk_va_d;

   // Entry payload; tag always holds va[31:10], compared at the entry's size.
   logic [21:0]        tag_q  [ENTRIES];
   logic [21:0]        base_q [ENTRIES];
   logic [1:0]         size_q [ENTRIES];
   logic [1:0]         ap_q   [ENTRIES];
   logic [3:0]         dom_q  [ENTRIES];
   logic               cbit_q [ENTRIES];

   logic               hit;
   logic [IDX_W-1:0]   hit_idx;
   logic [IDX_W-1:0]   victim;
   logic               fill_we;
   logic [31:0]        hit_phy;
   logic [7:0]         hit_fsr;
   logic [1:0]         dac_fld;
   logic [1:0]         h_size;
   logic [21:0]        h_base;
   logic [3:0]         h_dom;
   logic               h_sec;

   // Buffering bit only; the walker's B bit has no use here.
   logic               unused_b_bit;
   assign unused_b_bit = i_fill_cb[0];

   function automatic logic tag_match(input logic [21:0] tag, input logic [1:0] sz,
                                      input logic [31:0] va);
      logic m;
      case (sz)
         SZ_SECTION: m = (tag[21:10] == va[31:20]);
         SZ_LARGE:   m = (tag[21:6]  == va[31:16]);
         SZ_SMALL:   m = (tag[21:2]  == va[31:12]);
         default:    m = (tag        == va[31:10]);
      endcase
      return m;
   endfunction

   // Client-domain access rights from AP and the S/R bits.
   function automatic logic apsr_ok(input logic user, input logic wr,
                                    input logic [1:0] ap, input logic [1:0] sr);
      logic ok;
      case (ap)
         2'b00: case (sr)
                   2'b01:   ok = !wr;
                   2'b10:   ok = !user && !wr;
                   default: ok = 1'b0;
                endcase
         2'b01:   ok = !user;
         2'b10:   ok = !user || !wr;
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

   // Lowest matching index wins; scan downward so the lowest assignment sticks.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (valid_q[i] && tag_match(tag_q[i], size_q[i], va_q)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Victim: lowest invalid entry, otherwise the round-robin pointer.
   always_comb begin
      victim = ptr_q;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (!valid_q[i]) victim = IDX_W'(i);
      end
   end

   // Translation and permission result for the hit entry.
   always_comb begin
      h_size  = size_q[hit_idx];
      h_base  = base_q[hit_idx];
      h_dom   = dom_q[hit_idx];
      h_sec   = (h_size == SZ_SECTION);
      dac_fld = i_dac_reg[{h_dom, 1'b0} +: 2];
      case (h_size)
         SZ_SECTION: hit_phy = {h_base[11:0], va_q[19:0]};
         SZ_LARGE:   hit_phy = {h_base[15:0], va_q[15:0]};
         SZ_SMALL:   hit_phy = {h_base[19:0], va_q[11:0]};
         default:    hit_phy = {h_base,       va_q[9:0]};
      endcase
      case (dac_fld)
         2'b11:   hit_fsr = 8'h00;
         2'b01:   hit_fsr = apsr_ok(user_q, wr_q, ap_q[hit_idx], i_sr) ? 8'h00 :
                            {h_dom, (h_sec ? 4'hD : 4'hF)};
         default: hit_fsr = {h_dom, (h_sec ? 4'h9 : 4'hB)};
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      ptr_d       = ptr_q;
      va_d        = va_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      user_d      = user_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      phy_d       = phy_q;
      fsr_d       = fsr_q;
      far_d       = far_q;
      cache_d     = cache_q;
      walk_d      = walk_q;
      walk_va_d   = walk_va_q;
      fill_we     = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               va_d        = i_va;
               rd_d        = i_rd;
               wr_d        = i_wr;
               user_d      = i_user;
               req_ready_d = 1'b0;
               state_d     = CHECK;
            end
         end
         CHECK: begin
            if (!i_mmu_en || !(rd_q || wr_q)) begin
               phy_d       = va_q;
               fsr_d       = 8'h00;
               cache_d     = 1'b0;
               far_d       = va_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (hit) begin
               phy_d       = hit_phy;
               fsr_d       = hit_fsr;
               cache_d     = cbit_q[hit_idx];
               far_d       = va_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               walk_d      = 1'b1;
               walk_va_d   = va_q;
               state_d     = WALK;
            end
         end
         WALK: begin
            if (i_fill_valid) begin
               walk_d = 1'b0;
               if (i_inv) begin
                  // Flush wins over the fill; replay forces a fresh walk.
                  state_d = CHECK;
               end else if (!i_fill_fault) begin
                  fill_we = 1'b1;
                  state_d = CHECK;
               end else begin
                  phy_d       = va_q;
                  fsr_d       = i_fill_fsr;
                  cache_d     = 1'b0;
                  far_d       = va_q;
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end
            end
         end
         default: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
      endcase

      if (fill_we) begin
         valid_d[victim] = 1'b1;
         if (victim == ptr_q) ptr_d = ptr_q + IDX_W'(1);
      end
      if (i_inv) begin
         valid_d = '0;
         ptr_d   = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         ptr_q       <= '0;
         va_q        <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         user_q      <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         phy_q       <= '0;
         fsr_q       <= '0;
         far_q       <= '0;
         cache_q     <= 1'b0;
         walk_q      <= 1'b0;
         walk_va_q   <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         ptr_q       <= ptr_d;
         va_q        <= va_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         user_q      <= user_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         phy_q       <= phy_d;
         fsr_q       <= fsr_d;
         far_q       <= far_d;
         cache_q     <= cache_d;
         walk_q      <= walk_d;
         walk_va_q   <= walk_va_d;
      end
   end

   // Entry payload storage, written only on an accepted, non-flushed fill.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            tag_q[i]  <= '0;
            base_q[i] <= '0;
            size_q[i] <= '0;
            ap_q[i]   <= '0;
            dom_q[i]  <= '0;
            cbit_q[i] <= 1'b0;
         end
      end else if (fill_we) begin
         tag_q[victim]  <= va_q[31:10];
         base_q[victim] <= i_fill_base;
         size_q[victim] <= i_fill_size;
         ap_q[victim]   <= i_fill_ap;
         dom_q[victim]  <= i_fill_dom;
         cbit_q[victim] <= i_fill_cb[1];
      end
   end

   assign o_req_ready = req_ready_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_phy_addr  = phy_q;
   assign o_fsr       = fsr_q;
   assign o_far       = far_q;
   assign o_cacheable = cache_q;
   assign o_walk      = walk_q;
   assign o_walk_va   = walk_va_q;

endmodule

// File: tb/tb_zap_utlb.sv
// Self-checking bench for zap_utlb: directed scenarios plus randomized traffic
// checked against a region-based TLB model.
module tb_zap_utlb;
   localparam int NENT = 8;

   logic        clk = 1'b0;
   logic        i_reset_n;
   logic        i_req_valid, i_rd, i_wr, i_user, i_rsp_ready, i_inv;
   logic [31:0] i_va;
   logic        i_fill_valid, i_fill_fault;
   logic [7:0]  i_fill_fsr;
   logic [1:0]  i_fill_size, i_fill_ap, i_fill_cb;
   logic [21:0] i_fill_base;
   logic [3:0]  i_fill_dom;
   wire         o_req_ready, o_rsp_valid, o_cacheable, o_walk;
   wire  [31:0] o_phy_addr, o_far, o_walk_va;
   wire  [7:0]  o_fsr;

   // Environment / walker configuration
   logic        g_mmu, g_fault;
   logic [1:0]  g_sr, g_size, g_ap, g_cb;
   logic [31:0] g_dac;
   logic [3:0]  g_dom;
   logic [7:0]  g_fsr;
   logic [21:0] g_boff;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   zap_utlb #(.ENTRIES(NENT)) dut (
      .i_clk(clk), .i_reset_n(i_reset_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_va(i_va), .i_rd(i_rd), .i_wr(i_wr), .i_user(i_user),
      .i_mmu_en(g_mmu), .i_sr(g_sr), .i_dac_reg(g_dac),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_phy_addr(o_phy_addr), .o_fsr(o_fsr), .o_far(o_far), .o_cacheable(o_cacheable),
      .o_walk(o_walk), .o_walk_va(o_walk_va),
      .i_fill_valid(i_fill_valid), .i_fill_fault(i_fill_fault), .i_fill_fsr(i_fill_fsr),
      .i_fill_size(i_fill_size), .i_fill_base(i_fill_base), .i_fill_ap(i_fill_ap),
      .i_fill_dom(i_fill_dom), .i_fill_cb(i_fill_cb), .i_inv(i_inv)
   );

   // ---------------- reference model: entries as address regions ----------------
   bit          m_valid [NENT];
   logic [31:0] m_vbase [NENT], m_pbase [NENT], m_pgsz [NENT];
   logic [1:0]  m_ap [NENT], m_cb [NENT];
   logic [3:0]  m_dom [NENT];
   int          m_ptr;

   function automatic int page_shift(input logic [1:0] sz);
      case (sz)
         2'd0:    return 20;
         2'd1:    return 16;
         2'd2:    return 12;
         default: return 10;
      endcase
   endfunction

   // Walker's physical frame number for a VA, right-aligned to the page size.
   function automatic logic [21:0] pt_base(input logic [31:0] va, input logic [1:0] sz);
      int sh;
      logic [31:0] v;
      sh = page_shift(sz);
      v  = ((va >> sh) + {10'd0, g_boff}) & ((32'd1 << (32 - sh)) - 32'd1);
      return v[21:0];
   endfunction

   task automatic model_invalidate();
      for (int i = 0; i < NENT; i++) m_valid[i] = 0;
      m_ptr = 0;
   endtask

   function automatic int model_find(input logic [31:0] va);
      for (int i = 0; i < NENT; i++)
         if (m_valid[i] && ((va & ~(m_pgsz[i] - 32'd1)) == m_vbase[i])) return i;
      return -1;
   endfunction

   task automatic model_insert(input logic [31:0] va);
      int v = -1;
      int sh = page_shift(g_size);
      for (int i = 0; i < NENT; i++) if (!m_valid[i] && v < 0) v = i;
      if (v < 0) v = m_ptr;
      if (v == m_ptr) m_ptr = (m_ptr + 1) % NENT;
      m_valid[v] = 1;
      m_pgsz[v]  = 32'd1 << sh;
      m_vbase[v] = va & ~(m_pgsz[v] - 32'd1);
      m_pbase[v] = {10'd0, pt_base(va, g_size)} << sh;
      m_ap[v]    = g_ap;
      m_dom[v]   = g_dom;
      m_cb[v]    = g_cb;
   endtask

   logic [31:0] e_phy;
   logic [7:0]  e_fsr;
   logic        e_cache;
   int          e_walks;

   task automatic model_access(input logic [31:0] va, input logic rd, input logic wr,
                               input logic user);
      int idx;
      logic [1:0] fld;
      logic [3:0] rights;  // {priv_rd, priv_wr, usr_rd, usr_wr}
      bit allowed, sec;
      e_walks = 0;
      if (!g_mmu || !(rd || wr)) begin
         e_phy = va; e_fsr = 8'h00; e_cache = 1'b0;
         return;
      end
      idx = model_find(va);
      if (idx < 0) begin
         e_walks = 1;
         if (g_fault) begin
            e_phy = va; e_fsr = g_fsr; e_cache = 1'b0;
            return;
         end
         model_insert(va);
         idx = model_find(va);
      end
      e_phy   = m_pbase[idx] + (va - m_vbase[idx]);
      e_cache = m_cb[idx][1];
      sec     = (m_pgsz[idx] == 32'h0010_0000);
      fld     = 2'((g_dac >> (2 * m_dom[idx])) & 32'd3);
      case (m_ap[idx])
         2'd0:    rights = (g_sr == 2'b01) ? 4'b1010 : (g_sr == 2'b10) ? 4'b1000 : 4'b0000;
         2'd1:    rights = 4'b1100;
         2'd2:    rights = 4'b1110;
         default: rights = 4'b1111;
      endcase
      allowed = user ? (wr ? rights[0] : rights[1]) : (wr ? rights[2] : rights[3]);
      if (fld == 2'b11)      e_fsr = 8'h00;
      else if (fld == 2'b01) e_fsr = allowed ? 8'h00 : {m_dom[idx], (sec ? 4'hD : 4'hF)};
      else                   e_fsr = {m_dom[idx], (sec ? 4'h9 : 4'hB)};
   endtask

   // ---------------- driver: one request, services walks, collects response ----------------
   logic [31:0] r_phy, r_far, r_wva;
   logic [7:0]  r_fsr;
   logic        r_cache;
   int          r_walks, r_lat;
   bit          r_stable, r_tmo;

   task automatic run_lookup(input logic [31:0] va, input logic rd, input logic wr,
                             input logic user, input bit inv_first, input int hold);
      int dly = 0, n = 0;
      bit prev_walk = 0, first_fill = 1, got = 0;
      r_walks = 0; r_lat = 0; r_stable = 1; r_tmo = 0; r_wva = '0;
      r_phy = '0; r_fsr = '0; r_far = '0; r_cache = 1'b0;
      @(negedge clk);
      i_req_valid = 1'b1; i_va = va; i_rd = rd; i_wr = wr; i_user = user;
      while (!o_req_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      i_req_valid = 1'b0; i_va = $urandom; i_rd = 1'($urandom); i_wr = 1'($urandom);
      i_user = 1'($urandom);
      for (int c = 0; c < 200; c++) begin
         i_fill_valid = 1'b0; i_inv = 1'b0;
         if (o_rsp_valid) begin got = 1; break; end
         if (o_walk) begin
            if (!prev_walk) begin r_walks++; r_wva = o_walk_va; dly = $urandom_range(0, 2); end
            if (dly == 0) begin
               i_fill_valid = 1'b1;
               i_fill_fault = (inv_first && first_fill) ? 1'b0 : g_fault;
               i_inv        = inv_first && first_fill;
               i_fill_fsr   = g_fsr;
               i_fill_size  = g_size;
               i_fill_base  = pt_base(va, g_size);
               i_fill_ap    = g_ap;
               i_fill_dom   = g_dom;
               i_fill_cb    = g_cb;
               first_fill   = 0;
            end else dly--;
         end
         prev_walk = o_walk;
         @(posedge clk); r_lat++;
         @(negedge clk);
      end
      i_fill_valid = 1'b0; i_inv = 1'b0;
      if (!got) begin r_tmo = 1; return; end
      r_phy = o_phy_addr; r_fsr = o_fsr; r_far = o_far; r_cache = o_cacheable;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); @(negedge clk);
         if (o_rsp_valid !== 1'b1 || o_req_ready !== 1'b0 || o_phy_addr !== r_phy ||
             o_fsr !== r_fsr || o_far !== r_far || o_cacheable !== r_cache) r_stable = 0;
      end
      i_rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      i_rsp_ready = 1'b0;
   endtask

   task automatic pulse_inv();
      @(negedge clk); i_inv = 1'b1;
      @(negedge clk); i_inv = 1'b0;
      model_invalidate();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      i_reset_n = 1'b0; i_req_valid = 0; i_rd = 0; i_wr = 0; i_user = 0; i_va = '0;
      i_rsp_ready = 0; i_inv = 0; i_fill_valid = 0; i_fill_fault = 0; i_fill_fsr = '0;
      i_fill_size = '0; i_fill_base = '0; i_fill_ap = '0; i_fill_dom = '0; i_fill_cb = '0;
      g_mmu = 1; g_fault = 0; g_sr = 2'b00; g_size = 2; g_ap = 3; g_cb = 0; g_dac = '1;
      g_dom = 0; g_fsr = 0; g_boff = 0;
      model_invalidate();
      #12;
      checks++; if ({o_rsp_valid, o_walk, o_cacheable} !== 3'b000) begin failures++;
         $display("FAIL rst_flags got=%b exp=000", {o_rsp_valid, o_walk, o_cacheable}); end
      checks++; if ({o_phy_addr, o_far, o_walk_va, o_fsr} !== 104'd0) begin failures++;
         $display("FAIL rst_data got=%h exp=0", {o_phy_addr, o_far, o_walk_va, o_fsr}); end
      @(negedge clk); i_reset_n = 1'b1;
      @(negedge clk);
      checks++; if (o_req_ready !== 1'b1) begin failures++;
         $display("FAIL rst_ready got=%b exp=1", o_req_ready); end
   endtask

   task automatic test_mmu_off();
      g_mmu = 0;
      model_access(32'h1234_5678, 1, 0, 0);
      run_lookup(32'h1234_5678, 1, 0, 0, 0, 0);
      checks++; if (r_tmo || r_phy !== 32'h1234_5678 || r_phy !== e_phy) begin failures++;
         $display("FAIL off_phy got=%h exp=%h tmo=%0d", r_phy, e_phy, r_tmo); end
      checks++; if (r_fsr !== 8'h00 || r_far !== 32'h1234_5678 || r_cache !== 1'b0) begin
         failures++; $display("FAIL off_rsp got fsr=%h far=%h c=%b exp 00/12345678/0",
                              r_fsr, r_far, r_cache); end
      checks++; if (r_lat !== 1 || r_walks !== 0) begin failures++;
         $display("FAIL off_lat got lat=%0d walks=%0d exp 1/0", r_lat, r_walks); end
      g_mmu = 1;
      model_access(32'h0BAD_F00D, 0, 0, 0);
      run_lookup(32'h0BAD_F00D, 0, 0, 0, 0, 0);
      checks++; if (r_phy !== 32'h0BAD_F00D || r_walks !== 0 || r_fsr !== 8'h00) begin
         failures++; $display("FAIL noacc got phy=%h walks=%0d fsr=%h exp 0badf00d/0/00",
                              r_phy, r_walks, r_fsr); end
   endtask

   task automatic test_section_fill();
      pulse_inv();
      g_size = 0; g_boff = 22'h7FF; g_dom = 2; g_ap = 3; g_cb = 2'b10; g_dac = 32'h0000_0010;
      g_fault = 0;
      model_access(32'h0010_0ABC, 1, 0, 1);
      run_lookup(32'h0010_0ABC, 1, 0, 1, 0, 0);
      checks++; if (r_phy !== 32'h8000_0ABC || r_phy !== e_phy || r_fsr !== 8'h00) begin
         failures++; $display("FAIL sec_phy got=%h fsr=%h exp=80000abc fsr=00", r_phy, r_fsr); end
      checks++; if (r_walks !== 1 || r_wva !== 32'h0010_0ABC || r_cache !== 1'b1) begin
         failures++; $display("FAIL sec_walk got walks=%0d wva=%h c=%b exp 1/00100abc/1",
                              r_walks, r_wva, r_cache); end
      model_access(32'h001F_FFFC, 0, 1, 0);
      run_lookup(32'h001F_FFFC, 0, 1, 0, 0, 0);
      checks++; if (r_walks !== 0 || r_lat !== 1 || r_phy !== 32'h800F_FFFC ||
                    r_phy !== e_phy) begin failures++;
         $display("FAIL sec_hit got walks=%0d lat=%0d phy=%h exp 0/1/800ffffc",
                  r_walks, r_lat, r_phy); end
   endtask

   task automatic test_domain_fault();
      g_dom = 3; g_dac = 32'h0000_0000; g_ap = 3; g_fault = 0; g_boff = 22'h00123;
      g_size = 2;
      model_access(32'h2000_3123, 1, 0, 0);
      run_lookup(32'h2000_3123, 1, 0, 0, 0, 0);
      checks++; if (r_fsr !== 8'h3B || r_fsr !== e_fsr || r_phy !== e_phy) begin failures++;
         $display("FAIL dom_page got fsr=%h phy=%h exp 3b/%h", r_fsr, r_phy, e_phy); end
      g_size = 0;
      model_access(32'h3000_0000, 0, 1, 1);
      run_lookup(32'h3000_0000, 0, 1, 1, 0, 0);
      checks++; if (r_fsr !== 8'h39 || r_fsr !== e_fsr) begin failures++;
         $display("FAIL dom_sec got fsr=%h exp 39", r_fsr); end
      // Client domain, AP=01 user write -> page permission fault
      g_dac = 32'h0000_0040; g_ap = 1; g_size = 1;
      model_access(32'h5555_0000, 0, 1, 1);
      run_lookup(32'h5555_0000, 0, 1, 1, 0, 0);
      checks++; if (r_fsr !== 8'h3F || r_fsr !== e_fsr) begin failures++;
         $display("FAIL perm_page got fsr=%h exp 3f", r_fsr); end
   endtask

   task automatic test_eviction();
      logic [31:0] va;
      pulse_inv();
      g_size = 2; g_dom = 0; g_dac = 32'h0000_0003; g_ap = 3; g_fault = 0; g_boff = 22'h0AAAA;
      for (int k = 0; k <= NENT; k++) begin
         va = 32'h4000_0000 + 32'(k) * 32'h1000 + 32'h44;
         model_access(va, 1, 0, 0);
         run_lookup(va, 1, 0, 0, 0, 0);
         checks++; if (r_walks !== 1 || r_phy !== e_phy) begin failures++;
            $display("FAIL evict_fill%0d got walks=%0d phy=%h exp 1/%h", k, r_walks, r_phy, e_phy); end
      end
      for (int k = 1; k <= NENT; k++) begin
         va = 32'h4000_0000 + 32'(k) * 32'h1000 + 32'h88;
         model_access(va, 1, 0, 0);
         run_lookup(va, 1, 0, 0, 0, 0);
         checks++; if (r_walks !== 0 || r_phy !== e_phy) begin failures++;
            $display("FAIL evict_hit%0d got walks=%0d phy=%h exp 0/%h", k, r_walks, r_phy, e_phy); end
      end
      model_access(32'h4000_0010, 1, 0, 0);
      run_lookup(32'h4000_0010, 1, 0, 0, 0, 0);
      checks++; if (r_walks !== 1 || r_phy !== e_phy) begin failures++;
         $display("FAIL evict_first got walks=%0d phy=%h exp 1/%h", r_walks, r_phy, e_phy); end
   endtask

   task automatic test_inv_fill();
      g_size = 3; g_dac = 32'h0000_0003; g_dom = 0; g_ap = 3; g_fault = 1; g_fsr = 8'h05;
      model_invalidate();
      model_access(32'h6000_0400, 1, 0, 0);
      run_lookup(32'h6000_0400, 1, 0, 0, 1, 0);
      checks++; if (r_walks !== 2 || r_wva !== 32'h6000_0400) begin failures++;
         $display("FAIL inv_rewalk got walks=%0d wva=%h exp 2/60000400", r_walks, r_wva); end
      checks++; if (r_fsr !== 8'h05 || r_fsr !== e_fsr || r_phy !== 32'h6000_0400 ||
                    r_far !== 32'h6000_0400) begin failures++;
         $display("FAIL fault_rsp got fsr=%h phy=%h far=%h exp 05/60000400", r_fsr, r_phy, r_far); end
      g_fault = 0;
      model_access(32'h6000_0400, 1, 0, 0);
      run_lookup(32'h6000_0400, 1, 0, 0, 0, 0);
      checks++; if (r_walks !== 1 || e_walks !== 1 || r_phy !== e_phy) begin failures++;
         $display("FAIL fault_nowrite got walks=%0d phy=%h exp 1/%h", r_walks, r_phy, e_phy); end
   endtask

   task automatic test_backpressure();
      g_mmu = 1; g_fault = 0;
      model_access(32'h6000_0404, 1, 0, 0);
      run_lookup(32'h6000_0404, 1, 0, 0, 0, 3);
      checks++; if (r_stable !== 1 || r_phy !== e_phy || r_far !== 32'h6000_0404) begin
         failures++; $display("FAIL bp_stable got stable=%0d phy=%h exp 1/%h", r_stable, r_phy, e_phy); end
      checks++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin failures++;
         $display("FAIL bp_release got v=%b rdy=%b exp 0/1", o_rsp_valid, o_req_ready); end
   endtask

   task automatic test_reset_midwalk();
      int n = 0;
      pulse_inv();
      g_fault = 0; g_size = 3;
      @(negedge clk);
      i_req_valid = 1'b1; i_va = 32'hC000_0400; i_rd = 1; i_wr = 0; i_user = 0;
      @(posedge clk); @(negedge clk); i_req_valid = 1'b0;
      while (!o_walk && n < 20) begin @(negedge clk); n++; end
      checks++; if (o_walk !== 1'b1) begin failures++;
         $display("FAIL mid_walk got=%b exp=1", o_walk); end
      i_reset_n = 1'b0; #1;
      checks++; if ({o_rsp_valid, o_walk, o_cacheable, o_fsr, o_phy_addr, o_far, o_walk_va} !== '0) begin
         failures++; $display("FAIL mid_rst got v=%b w=%b wva=%h phy=%h exp all zero",
                              o_rsp_valid, o_walk, o_walk_va, o_phy_addr); end
      @(negedge clk); i_reset_n = 1'b1;
      @(negedge clk);
      checks++; if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin failures++;
         $display("FAIL mid_ready got rdy=%b v=%b exp 1/0", o_req_ready, o_rsp_valid); end
      model_invalidate();
      model_access(32'hC000_0400, 1, 0, 0);
      run_lookup(32'hC000_0400, 1, 0, 0, 0, 0);
      checks++; if (r_walks !== 1 || r_phy !== e_phy) begin failures++;
         $display("FAIL mid_nowrite got walks=%0d phy=%h exp 1/%h", r_walks, r_phy, e_phy); end
   endtask

   task automatic test_random();
      logic [31:0] va;
      logic rd, wr, user;
      for (int it = 0; it < 150; it++) begin
         g_mmu   = ($urandom_range(0, 9) != 0);
         g_fault = ($urandom_range(0, 7) == 0);
         g_fsr   = 8'($urandom);
         g_size  = 2'($urandom);
         g_ap    = 2'($urandom);
         g_cb    = 2'($urandom);
         g_dom   = 4'($urandom);
         g_sr    = 2'($urandom);
         g_dac   = $urandom;
         g_boff  = 22'($urandom);
         va   = (32'($urandom_range(0, 3)) << 20) | (32'($urandom_range(0, 7)) << 12) |
                (32'($urandom) & 32'h0000_0FFF);
         rd   = 1'($urandom); wr = 1'($urandom); user = 1'($urandom);
         model_access(va, rd, wr, user);
         run_lookup(va, rd, wr, user, 0, $urandom_range(0, 2));
         checks++; if (r_tmo || r_phy !== e_phy || r_far !== va) begin failures++;
            $display("FAIL rnd_phy it=%0d got phy=%h far=%h exp %h/%h", it, r_phy, r_far, e_phy, va); end
         checks++; if (r_fsr !== e_fsr || r_cache !== e_cache) begin failures++;
            $display("FAIL rnd_fsr it=%0d got fsr=%h c=%b exp %h/%b", it, r_fsr, r_cache, e_fsr, e_cache); end
         checks++; if (r_walks !== e_walks || (e_walks != 0 && r_wva !== va)) begin failures++;
            $display("FAIL rnd_walk it=%0d got walks=%0d wva=%h exp %0d/%h", it, r_walks, r_wva, e_walks, va); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mmu_off();
      test_section_fill();
      test_domain_fault();
      test_eviction();
      test_inv_fill();
      test_backpressure();
      test_reset_midwalk();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
